// File: rtl/store_buffer_pkg.sv
// Shared types and defaults for the store write buffer: entry layout, default
// geometry and pointer width derived from the depth.
package store_buffer_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;
  localparam int SB_PTR_W  = $clog2(SB_DEPTH);

  // Addresses are held as word addresses; the byte offset is never stored.
  typedef struct packed {
    logic                   valid;
    logic [SB_ADDR_W-1:2]   waddr;
    logic [SB_DATA_W-1:0]   data;
  } sb_entry_t;

endpackage

// File: rtl/store_write_buffer_if.sv
// Memory-side drain port of the store write buffer.
interface store_write_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  // Handshake: the buffer raises mem_valid with a stable mem_addr/mem_wdata
  // and holds them until a rising clk edge where mem_ready is also 1; that
  // edge is the single transfer. mem_valid never depends on mem_ready.
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    input  mem_ready
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready
  );

endinterface

// File: rtl/sb_fwd_match.sv
// Youngest-match search over the store buffer entries for load forwarding.
// Entries are visited oldest to youngest so the last hit wins.
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0]  entries,
  input  logic [PTR_W-1:0]       head,
  input  logic [SB_ADDR_W-1:2]   qaddr,
  output logic                   hit,
  output logic [SB_DATA_W-1:0]   data
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (entries[idx].valid && (entries[idx].waddr == qaddr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// Word-granular store buffer: FIFOs core stores, drains them in order to
// memory over a valid/ready port and forwards buffered data to loads.
module store_write_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic [ADDR_W-1:0]        DataAdr,
  input  logic [DATA_W-1:0]        WriteData,
  input  logic                     MemRead,
  output logic                     StallStore,
  output logic                     FwdHit,
  output logic [DATA_W-1:0]        FwdData,
  store_write_buffer_if.master     mem,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t [DEPTH-1:0] entries;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic push;
  logic pop;
  logic full;
  logic match_hit;
  logic [DATA_W-1:0] match_data;
  logic unused_byte_offset;

  assign unused_byte_offset = ^DataAdr[1:0];

  assign full  = (count == CNT_W'(DEPTH));
  assign Empty = (count == '0);
  assign Count = count;

  // Stall is derived from registered occupancy only, so mem_ready never
  // reaches back into the core's store path within a cycle.
  assign StallStore = MemWrite && full;
  assign push       = MemWrite && !full;
  assign pop        = mem.mem_valid && mem.mem_ready;

  assign mem.mem_valid = !Empty;
  assign mem.mem_addr  = mem.mem_valid ? {entries[head].waddr, 2'b00} : '0;
  assign mem.mem_wdata = mem.mem_valid ? entries[head].data : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entries <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      // Push and pop never address the same slot: that needs count 0 or DEPTH,
      // where one of the two is blocked.
      if (push) begin
        entries[tail] <= '{valid: 1'b1,
                           waddr: DataAdr[ADDR_W-1:2],
                           data:  WriteData};
        tail          <= tail + 1'b1;
      end
      if (pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fwd_match (
    .entries (entries),
    .head    (head),
    .qaddr   (DataAdr[ADDR_W-1:2]),
    .hit     (match_hit),
    .data    (match_data)
  );

  // The store arriving this cycle is not yet in entries, so it never forwards.
  assign FwdHit  = MemRead && match_hit;
  assign FwdData = FwdHit ? match_data : '0;

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed scenarios plus randomized traffic
// checked against a queue-based model of the buffer contents.
module tb_store_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          MemWrite = 1'b0;
  logic [AW-1:0] DataAdr = '0;
  logic [DW-1:0] WriteData = '0;
  logic          MemRead = 1'b0;
  logic          StallStore;
  logic          FwdHit;
  logic [DW-1:0] FwdData;
  logic          Empty;
  logic [CW-1:0] Count;

  store_write_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

  store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .DataAdr    (DataAdr),
    .WriteData  (WriteData),
    .MemRead    (MemRead),
    .StallStore (StallStore),
    .FwdHit     (FwdHit),
    .FwdData    (FwdData),
    .mem        (mem_bus),
    .Empty      (Empty),
    .Count      (Count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: buffered stores oldest first, plus drain logs
  logic [AW-1:0]    mq_addr[$];
  logic [DW-1:0]    mq_data[$];
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] got_q[$];

  logic          o_stall, o_hit, o_valid, o_empty;
  logic [CW-1:0] o_count;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wdata, o_fdata;
  logic          e_stall, e_hit, e_valid, e_empty;
  logic [CW-1:0] e_count;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_fdata;

  task automatic clear_model();
    mq_addr.delete();
    mq_data.delete();
    exp_q.delete();
    got_q.delete();
  endtask

  // driver: one clock cycle; samples DUT and model at negedge, updates model at posedge
  task automatic tick(input logic mw, input logic [AW-1:0] adr, input logic [DW-1:0] wd,
                      input logic mr, input logic rdy);
    int n;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    MemWrite = mw; DataAdr = adr; WriteData = wd; MemRead = mr;
    mem_bus.mem_ready = rdy;
    @(negedge clk);
    o_stall = StallStore; o_hit = FwdHit; o_fdata = FwdData;
    o_valid = mem_bus.mem_valid; o_addr = mem_bus.mem_addr; o_wdata = mem_bus.mem_wdata;
    o_empty = Empty; o_count = Count;
    n = mq_addr.size();
    e_count = CW'(n);
    e_empty = (n == 0);
    e_valid = (n != 0);
    e_stall = mw && (n == DEPTH);
    e_addr  = (n != 0) ? mq_addr[0] : '0;
    e_wdata = (n != 0) ? mq_data[0] : '0;
    e_hit = 1'b0;
    e_fdata = '0;
    if (mr) begin
      for (int i = 0; i < n; i++) begin
        if (mq_addr[i] == {adr[AW-1:2], 2'b00}) begin
          e_hit = 1'b1;
          e_fdata = mq_data[i];
        end
      end
    end
    if (o_valid && rdy) got_q.push_back({o_addr, o_wdata});
    @(posedge clk);
    if (n > 0 && rdy) begin
      pa = mq_addr.pop_front();
      pd = mq_data.pop_front();
      exp_q.push_back({pa, pd});
    end
    if (mw && n < DEPTH) begin
      mq_addr.push_back({adr[AW-1:2], 2'b00});
      mq_data.push_back(wd);
    end
    #1;
  endtask

  task automatic idle(input logic rdy);
    tick(1'b0, '0, '0, 1'b0, rdy);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (Count !== '0 || Empty !== 1'b1 || mem_bus.mem_valid !== 1'b0 || StallStore !== 1'b0 ||
        FwdHit !== 1'b0 || mem_bus.mem_addr !== '0 || mem_bus.mem_wdata !== '0 || FwdData !== '0) begin
      n_fail++;
      $display("FAIL reset_values got count=%0d empty=%b valid=%b stall=%b hit=%b addr=%0h wdata=%0h fdata=%0h exp 0/1/0/0/0/0/0/0",
               Count, Empty, mem_bus.mem_valid, StallStore, FwdHit, mem_bus.mem_addr, mem_bus.mem_wdata, FwdData);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    clear_model();
    for (int c = 0; c < 10; c++) begin
      idle(1'b1);
      n_cmp++;
      if (o_empty !== 1'b1 || o_count !== '0 || o_valid !== 1'b0 || o_stall !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset cycle %0d got empty=%b count=%0d valid=%b stall=%b exp 1/0/0/0",
                 c, o_empty, o_count, o_valid, o_stall);
      end
    end
  endtask

  task automatic test_in_order();
    clear_model();
    tick(1'b1, 32'd96, 32'd7, 1'b0, 1'b1);
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL no_bypass got valid=%b exp 0", o_valid);
    end
    tick(1'b1, 32'd100, 32'd25, 1'b0, 1'b1);
    n_cmp++;
    if (o_valid !== 1'b1 || o_addr !== 32'd96 || o_wdata !== 32'd7) begin
      n_fail++;
      $display("FAIL first_drain got valid=%b addr=%0d data=%0d exp 1/96/7", o_valid, o_addr, o_wdata);
    end
    idle(1'b1);
    n_cmp++;
    if (o_valid !== 1'b1 || o_addr !== 32'd100 || o_wdata !== 32'd25) begin
      n_fail++;
      $display("FAIL second_drain got valid=%b addr=%0d data=%0d exp 1/100/25", o_valid, o_addr, o_wdata);
    end
    idle(1'b1);
    n_cmp++;
    if (o_empty !== 1'b1 || o_count !== '0 || got_q.size() != 2) begin
      n_fail++;
      $display("FAIL in_order_empty got empty=%b count=%0d drained=%0d exp 1/0/2", o_empty, o_count, got_q.size());
    end
  endtask

  task automatic test_full_stall();
    logic [AW-1:0] want;
    clear_model();
    for (int i = 0; i < 5; i++) tick(1'b1, AW'(4 * i), $urandom, 1'b0, 1'b0);
    n_cmp++;
    if (o_count !== CW'(DEPTH) || o_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL full_stall got count=%0d stall=%b exp %0d/1", o_count, o_stall, DEPTH);
    end
    tick(1'b1, 32'd16, 32'hABCD, 1'b0, 1'b1);
    n_cmp++;
    if (o_stall !== 1'b1 || o_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL stall_during_pop got stall=%b addr=%0d exp 1/0", o_stall, o_addr);
    end
    tick(1'b1, 32'd16, 32'hABCD, 1'b0, 1'b1);
    n_cmp++;
    if (o_stall !== 1'b0 || o_count !== CW'(DEPTH - 1) || o_addr !== 32'd4) begin
      n_fail++;
      $display("FAIL retry_accept got stall=%b count=%0d addr=%0d exp 0/%0d/4", o_stall, o_count, DEPTH - 1, o_addr);
    end
    for (int c = 0; c < DEPTH + 2; c++) idle(1'b1);
    n_cmp++;
    if (got_q.size() != 5 || o_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL full_drain_count got %0d empty=%b exp 5/1", got_q.size(), o_empty);
    end
    for (int i = 0; i < got_q.size() && i < 5; i++) begin
      want = AW'(4 * i);
      n_cmp++;
      if (got_q[i][AW+DW-1:DW] !== want) begin
        n_fail++;
        $display("FAIL full_drain_order idx %0d got addr=%0d exp %0d", i, got_q[i][AW+DW-1:DW], want);
      end
    end
    n_cmp++;
    if (got_q.size() == 5 && got_q[4][DW-1:0] !== 32'hABCD) begin
      n_fail++;
      $display("FAIL retry_data got %0h exp abcd", got_q[4][DW-1:0]);
    end
  endtask

  task automatic test_forward();
    clear_model();
    tick(1'b1, 32'd100, 32'd25, 1'b0, 1'b0);
    tick(1'b1, 32'd101, 32'd42, 1'b0, 1'b0);
    tick(1'b0, 32'd102, 32'd0, 1'b1, 1'b0);
    n_cmp++;
    if (o_hit !== 1'b1 || o_fdata !== 32'd42) begin
      n_fail++;
      $display("FAIL fwd_youngest got hit=%b data=%0d exp 1/42", o_hit, o_fdata);
    end
    tick(1'b0, 32'd104, 32'd0, 1'b1, 1'b0);
    n_cmp++;
    if (o_hit !== 1'b0 || o_fdata !== '0) begin
      n_fail++;
      $display("FAIL fwd_miss got hit=%b data=%0d exp 0/0", o_hit, o_fdata);
    end
    tick(1'b0, 32'd100, 32'd0, 1'b0, 1'b0);
    n_cmp++;
    if (o_hit !== 1'b0 || o_fdata !== '0) begin
      n_fail++;
      $display("FAIL fwd_no_read got hit=%b data=%0d exp 0/0", o_hit, o_fdata);
    end
    tick(1'b1, 32'd200, 32'd9, 1'b1, 1'b0);
    n_cmp++;
    if (o_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_same_cycle_store got hit=%b exp 0", o_hit);
    end
    tick(1'b0, 32'd200, 32'd0, 1'b1, 1'b1);
    n_cmp++;
    if (o_hit !== 1'b1 || o_fdata !== 32'd9) begin
      n_fail++;
      $display("FAIL fwd_next_cycle got hit=%b data=%0d exp 1/9", o_hit, o_fdata);
    end
    idle(1'b1);
    tick(1'b0, 32'd100, 32'd0, 1'b1, 1'b1);
    n_cmp++;
    if (o_hit !== 1'b0 || o_valid !== 1'b1 || o_addr !== 32'd200) begin
      n_fail++;
      $display("FAIL fwd_after_drain got hit=%b valid=%b addr=%0d exp 0/1/200", o_hit, o_valid, o_addr);
    end
    for (int c = 0; c < DEPTH; c++) idle(1'b1);
  endtask

  task automatic test_push_pop_wrap();
    int acc;
    clear_model();
    tick(1'b1, 32'd40, 32'h11, 1'b0, 1'b0);
    tick(1'b1, 32'd44, 32'h22, 1'b0, 1'b0);
    tick(1'b1, 32'd48, 32'h33, 1'b0, 1'b1);
    n_cmp++;
    if (o_count !== CW'(2) || o_addr !== 32'd40) begin
      n_fail++;
      $display("FAIL push_pop_pre got count=%0d addr=%0d exp 2/40", o_count, o_addr);
    end
    idle(1'b0);
    n_cmp++;
    if (o_count !== CW'(2) || o_addr !== 32'd44 || o_wdata !== 32'h22) begin
      n_fail++;
      $display("FAIL push_pop_post got count=%0d addr=%0d data=%0h exp 2/44/22", o_count, o_addr, o_wdata);
    end
    for (int c = 0; c < DEPTH; c++) idle(1'b1);
    clear_model();
    acc = 0;
    for (int g = 0; g < 400 && acc < 3 * DEPTH; g++) begin
      tick(1'b1, AW'(acc * 4 + 64), $urandom, 1'b0, 1'($urandom_range(0, 1)));
      if (!e_stall) acc++;
    end
    for (int c = 0; c < DEPTH + 2; c++) idle(1'b1);
    n_cmp++;
    if (got_q.size() != 3 * DEPTH || exp_q.size() != 3 * DEPTH) begin
      n_fail++;
      $display("FAIL wrap_count got %0d exp %0d (model %0d)", got_q.size(), 3 * DEPTH, exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wrap_order idx %0d got %0h exp %0h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic mw, mr, rdy;
    logic [AW-1:0] adr;
    clear_model();
    for (int c = 0; c < 500; c++) begin
      mw  = ($urandom_range(0, 9) < 6);
      mr  = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 9) < 4);
      adr = AW'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      tick(mw, adr, $urandom, mr, rdy);
      n_cmp++;
      if (o_count !== e_count || o_empty !== e_empty || o_stall !== e_stall || o_valid !== e_valid) begin
        n_fail++;
        $display("FAIL rand_status cycle %0d got cnt=%0d emp=%b stall=%b val=%b exp %0d/%b/%b/%b",
                 c, o_count, o_empty, o_stall, o_valid, e_count, e_empty, e_stall, e_valid);
      end
      n_cmp++;
      if (e_valid && (o_addr !== e_addr || o_wdata !== e_wdata)) begin
        n_fail++;
        $display("FAIL rand_head cycle %0d got %0h/%0h exp %0h/%0h", c, o_addr, o_wdata, e_addr, e_wdata);
      end
      n_cmp++;
      if (o_hit !== e_hit || o_fdata !== e_fdata) begin
        n_fail++;
        $display("FAIL rand_fwd cycle %0d got %b/%0h exp %b/%0h", c, o_hit, o_fdata, e_hit, e_fdata);
      end
    end
    for (int c = 0; c < DEPTH + 2; c++) idle(1'b1);
    n_cmp++;
    if (got_q.size() != exp_q.size() || o_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL rand_drain_count got %0d exp %0d empty=%b", got_q.size(), exp_q.size(), o_empty);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_drain_order idx %0d got %0h exp %0h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    clear_model();
    for (int i = 0; i < DEPTH; i++) tick(1'b1, AW'(8 * i + 300), $urandom, 1'b0, 1'b0);
    idle(1'b1);
    n_cmp++;
    if (Count !== CW'(DEPTH - 1)) begin
      n_fail++;
      $display("FAIL pre_reset_count got %0d exp %0d", Count, DEPTH - 1);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (Count !== '0 || mem_bus.mem_valid !== 1'b0 || Empty !== 1'b1 || mem_bus.mem_addr !== '0) begin
      n_fail++;
      $display("FAIL async_reset got count=%0d valid=%b empty=%b addr=%0h exp 0/0/1/0",
               Count, mem_bus.mem_valid, Empty, mem_bus.mem_addr);
    end
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    clear_model();
    tick(1'b1, 32'd100, 32'd25, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) idle(1'b1);
    n_cmp++;
    if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== {32'd100, 32'd25})) begin
      n_fail++;
      $display("FAIL post_reset_store got n=%0d first=%0h exp 1/%0h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : '0, {32'd100, 32'd25});
    end
  endtask

  initial begin
    mem_bus.mem_ready = 1'b1;
    test_reset();
    test_in_order();
    test_full_stall();
    test_forward();
    test_push_pop_wrap();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
